mat_mult_host: RTL and testbench
================================

Name: mat_mult_host

Overview:
- Host-side sequencer that drives the multiply2 matrix accelerator interface (mat_A, mat_B, start, done, mat_C), i.e. the initiator end of the multiplier handshake.
- Accepts operand elements over a valid/ready byte stream, assembles A and B, and issues start.
- Waits for done, captures mat_C, and streams the result out over a second valid/ready stream.
- Sits between the core-side bus adapter and multiply2 inside the acc subsystem.

Parameters:
- DATA_W, 8, element width in bits; must match multiply2.
- DIM, 2, matrix dimension; supported values are 2..4.
- TIMEOUT, 64, maximum cycles spent in WAIT before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand element valid.
- in_data  in  DATA_W  operand element. Order: A row-major, then B row-major; 2*DIM*DIM elements in total.
- in_ready  out  1  element accepted when in_valid && in_ready.
- out_valid  out  1  result element valid.
- out_data  out  DATA_W  result element, C in row-major order.
- out_last  out  1  high with the final C element.
- out_ready  in  1  result consumer ready.
- mat_A  out  DATA_W x [DIM][DIM]  operand A to the multiplier.
- mat_B  out  DATA_W x [DIM][DIM]  operand B to the multiplier.
- start  out  1  multiplier start request.
- mat_C  in  DATA_W x [DIM][DIM]  multiplier result.
- done  in  1  multiplier completion.
- busy  out  1  high in any state other than LOAD with a zero count.
- error  out  1  sticky timeout flag; tied 0 when the optional feature is compiled out.

Behaviour:
Reset:
- Asynchronous reset on rst; all of the following apply immediately:
  - state=LOAD, element counter=0.
  - mat_A, mat_B and the internal C buffer cleared to 0.
  - start=0, in_ready=0 during reset, out_valid=0, out_last=0, out_data=0, busy=0, error=0.
- Reset is legal in any state. An in-flight multiply is abandoned; a done arriving after reset release while in LOAD is ignored.

States:
- LOAD
  - in_ready=1.
  - Each accepted element is written to A[idx/DIM][idx%DIM] for idx<DIM*DIM, otherwise to B at the same mapping with idx-DIM*DIM.
  - Counter increments per accept.
  - On the accept of element 2*DIM*DIM-1: counter returns to 0, next state is START.
- START
  - start=1 for this cycle, in_ready=0.
  - Next state is WAIT.
- WAIT
  - start held at 1.
  - First cycle with done=1: latch mat_C into the C buffer, drive start=0 from the next cycle, next state is DRAIN.
  - done is treated as level or pulse; only its first high cycle in WAIT matters.
  - A done seen in START is not used; the block waits for done in WAIT.
- DRAIN
  - out_valid=1, out_data=C[cnt/DIM][cnt%DIM], out_last=(cnt==DIM*DIM-1).
  - Counter advances only on out_valid && out_ready; out_data is stable while stalled.
  - After the last transfer: counter=0, out_valid=0, next state is LOAD.

Latency and data rules:
- Last input accept to start rising: 1 cycle.
- done sample to first out_valid: 1 cycle.
- Operand registers hold their values from LOAD until the next LOAD overwrites them; the multiplier sees stable operands throughout WAIT.
- No arithmetic in this block. Results are passed through as DATA_W bits; overflow wrap is the multiplier's responsibility.
- in_ready=0 outside LOAD, so input and output never overlap: one job at a time.

Optional Feature:
- Macro ACC_MULT_TIMEOUT_EN.
- Defined:
  - Watchdog counter cleared on WAIT entry, increments each WAIT cycle.
  - On reaching TIMEOUT without done: start=0, error set (sticky until rst), C buffer left unchanged, state goes to LOAD directly with no DRAIN.
  - If done and timeout occur in the same cycle, done wins.
- Undefined: no watchdog; WAIT lasts until done; error is tied 0.

Decomposition:
- Package mat_mult_pkg holds:
  - DATA_W, DIM, N_ELEM=DIM*DIM.
  - typedef elem_t (logic [DATA_W-1:0]) and mat_t (elem_t [DIM-1:0][DIM-1:0]).
  - State enum {LOAD, START, WAIT, DRAIN}.
  - Index-to-row/column helper function.
- The FSM and counters stay in mat_mult_host.
- The output side is a natural sub-module: mat_mult_drain, a result buffer plus valid/ready serializer with out_last generation.

Test Plan:
- Load A all 2, B all 128, multiply2 connected -> start rises 1 cycle after the 8th accept; out_data 0,0,0,0 (512 mod 256); out_last on the 4th element.
- A=[[1,2],[3,4]], B=identity -> out stream 1,2,3,4 in row-major order, out_last only with 4.
- Same job with out_ready toggling 1,0,0,1,... -> no element lost or duplicated; out_data is held while stalled; exactly 4 transfers.
- rst asserted mid-WAIT, then a stray done pulse after release -> all outputs 0 at once, state LOAD, no out_valid, next job completes correctly.
- Gaps in in_valid between the 8 inputs -> start is not issued until all 8 are accepted; elements land at the correct indices.
- With ACC_MULT_TIMEOUT_EN and a stub that never asserts done -> start drops and error=1 at WAIT cycle 64; in_ready=1 the next cycle; error stays set across a following good job.

Source files
------------

// File: rtl/mat_mult_pkg.sv
// Shared types and sizing for the mat_mult host sequencer and its result drain.
package mat_mult_pkg;
   localparam int DATA_W = 8;
   localparam int DIM    = 2;
   localparam int N_ELEM = DIM * DIM;
   localparam int CNT_W  = $clog2(2 * N_ELEM);
   localparam int OUT_W  = $clog2(N_ELEM);

   typedef logic [DATA_W-1:0] elem_t;
   typedef elem_t [DIM-1:0][DIM-1:0] mat_t;

   typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

   // Row-major flat index to matrix row / column.
   function automatic int idx_row(input int idx);
      return idx / DIM;
   endfunction

   function automatic int idx_col(input int idx);
      return idx % DIM;
   endfunction
endpackage

// File: rtl/mat_mult_drain.sv
// Result buffer for mat_C plus the valid/ready serializer that streams it out row-major.
module mat_mult_drain
   import mat_mult_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             capture,
   input  mat_t             mat_C,
   input  logic             active,
   input  logic [OUT_W-1:0] idx,
   input  logic             out_ready,
   output logic             out_valid,
   output elem_t            out_data,
   output logic             out_last,
   output logic             fire
);
   elem_t c_buf [N_ELEM];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_ELEM; i++) c_buf[i] <= '0;
      end else if (capture) begin
         for (int i = 0; i < N_ELEM; i++) c_buf[i] <= mat_C[idx_row(i)][idx_col(i)];
      end
   end

   // Outputs are zero whenever the drain is idle so reset and LOAD look clean downstream.
   assign out_valid = active;
   assign out_data  = active ? c_buf[idx] : '0;
   assign out_last  = active && (idx == OUT_W'(N_ELEM - 1));
   assign fire      = active && out_ready;
endmodule

// File: rtl/mat_mult_host.sv
// Initiator side of the multiply2 handshake: load A/B from a byte stream, start, wait, drain C.
// Optional watchdog on the WAIT state is compiled in with ACC_MULT_TIMEOUT_EN.
module mat_mult_host
   import mat_mult_pkg::*;
#(
   parameter int TIMEOUT = 64
)
(
   input  logic  clk,
   input  logic  rst,
   input  logic  in_valid,
   input  elem_t in_data,
   output logic  in_ready,
   output logic  out_valid,
   output elem_t out_data,
   output logic  out_last,
   input  logic  out_ready,
   output mat_t  mat_A,
   output mat_t  mat_B,
   output logic  start,
   input  mat_t  mat_C,
   input  logic  done,
   output logic  busy,
   output logic  error
);
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             accept, fire, capture, drain_active, timeout;
   logic             last_in, last_out;

   assign accept   = in_valid && in_ready;
   assign last_in  = (cnt_reg == CNT_W'(2 * N_ELEM - 1));
   assign last_out = (cnt_reg == CNT_W'(N_ELEM - 1));
   assign capture  = (state_reg == WAIT) && done;
   assign busy     = !((state_reg == LOAD) && (cnt_reg == '0));

`ifdef ACC_MULT_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_reg;
   logic            error_reg;

   // done in the same cycle as expiry takes priority over the abort.
   assign timeout = (state_reg == WAIT) && !done && (wd_reg == WD_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_reg    <= '0;
         error_reg <= 1'b0;
      end else begin
         wd_reg <= (state_reg == WAIT) ? wd_reg + 1'b1 : '0;
         if (timeout) error_reg <= 1'b1;
      end
   end
   assign error = error_reg;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
   assign timeout        = 1'b0;
   assign error          = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= LOAD;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      in_ready     = 1'b0;
      start        = 1'b0;
      drain_active = 1'b0;
      case (state_reg)
         LOAD: begin
            in_ready = !rst;
            if (in_valid && !rst) begin
               if (last_in) begin
                  cnt_next   = '0;
                  state_next = START;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         START: begin
            start      = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            start = 1'b1;
            if (done)         state_next = DRAIN;
            else if (timeout) state_next = LOAD;
         end
         DRAIN: begin
            drain_active = 1'b1;
            if (fire) begin
               if (last_out) begin
                  cnt_next   = '0;
                  state_next = LOAD;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         default: state_next = LOAD;
      endcase
   end

   // Operands persist until the next job overwrites them, keeping them stable through WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mat_A <= '0;
         mat_B <= '0;
      end else if (accept) begin
         for (int i = 0; i < N_ELEM; i++) begin
            if (cnt_reg == CNT_W'(i))          mat_A[idx_row(i)][idx_col(i)] <= in_data;
            if (cnt_reg == CNT_W'(i + N_ELEM)) mat_B[idx_row(i)][idx_col(i)] <= in_data;
         end
      end
   end

   mat_mult_drain u_drain (
      .clk       (clk),
      .rst       (rst),
      .capture   (capture),
      .mat_C     (mat_C),
      .active    (drain_active),
      .idx       (cnt_reg[OUT_W-1:0]),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .fire      (fire)
   );
endmodule

// File: tb/tb_mat_mult_host.sv
// Directed table-driven bench for mat_mult_host with a behavioural multiply2 stub.
module tb_mat_mult_host;
   import mat_mult_pkg::*;

   localparam int TMO = 64;

   logic  clk = 1'b0;
   logic  rst;
   logic  in_valid;
   elem_t in_data;
   logic  in_ready;
   logic  out_valid;
   elem_t out_data;
   logic  out_last;
   logic  out_ready;
   mat_t  mat_A, mat_B, mat_C;
   logic  start, done, busy, error;
   logic  stub_done, stray_done, stub_en;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] a [4];
      logic [7:0] b [4];
      logic [7:0] c [4];
      bit         gap;
      bit         stall;
   } vec_t;

   vec_t vecs [5];

   always #5 clk = ~clk;

   assign done = stub_done | stray_done;

   mat_mult_host #(.TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .mat_A     (mat_A),
      .mat_B     (mat_B),
      .start     (start),
      .mat_C     (mat_C),
      .done      (done),
      .busy      (busy),
      .error     (error)
   );

   // multiply2 stand-in: answers a held start with the wrapped product and a one-cycle done.
   initial begin
      int lat;
      logic [7:0] s;
      stub_done = 1'b0;
      mat_C     = '0;
      lat       = 0;
      forever begin
         @(posedge clk);
         #1;
         stub_done = 1'b0;
         if (rst || !start || !stub_en) begin
            lat = 0;
         end else begin
            lat++;
            if (lat == 3) begin
               for (int r = 0; r < 2; r++)
                  for (int c = 0; c < 2; c++) begin
                     s = '0;
                     for (int k = 0; k < 2; k++) s = s + 8'(mat_A[r][k] * mat_B[k][c]);
                     mat_C[r][c] = s;
                  end
               stub_done = 1'b1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send(input logic [7:0] d, input int gap);
      int guard;
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
         chk("start_during_load", start, 0);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_load", in_ready, 1);
      chk("start_before_last", start, 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic load_job(input vec_t v);
      for (int i = 0; i < 8; i++)
         send(i < 4 ? v.a[i] : v.b[i-4], v.gap ? (i % 3) : 0);
      @(negedge clk);
      chk("start_latency", start, 1);
      chk("in_ready_start", in_ready, 0);
      for (int i = 0; i < 4; i++) begin
         chk("mat_A_elem", mat_A[i/2][i%2], v.a[i]);
         chk("mat_B_elem", mat_B[i/2][i%2], v.b[i]);
      end
   endtask

   task automatic drain(input vec_t v);
      int k    = 0;
      int cyc  = 0;
      int vcyc = 0;
      out_ready = 1'b0;
      while (k < 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            chk("out_data", out_data, v.c[k]);
            chk("out_last", out_last, (k == 3) ? 1 : 0);
            out_ready = v.stall ? ((vcyc % 3) == 0) : 1'b1;
            vcyc++;
            if (out_ready) k++;
         end else begin
            out_ready = 1'b0;
         end
      end
      chk("transfers", k, 4);
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_after", out_valid, 0);
      chk("busy_after", busy, 0);
      $display("job done: C = %0d %0d %0d %0d stall=%0d gap=%0d",
               v.c[0], v.c[1], v.c[2], v.c[3], v.stall, v.gap);
   endtask

   task automatic run_job(input vec_t v);
      load_job(v);
      drain(v);
   endtask

   initial begin
      vecs[0].a = '{2, 2, 2, 2};       vecs[0].b = '{128, 128, 128, 128};
      vecs[0].c = '{0, 0, 0, 0};       vecs[0].gap = 0; vecs[0].stall = 0;
      vecs[1].a = '{1, 2, 3, 4};       vecs[1].b = '{1, 0, 0, 1};
      vecs[1].c = '{1, 2, 3, 4};       vecs[1].gap = 0; vecs[1].stall = 0;
      vecs[2].a = '{1, 2, 3, 4};       vecs[2].b = '{1, 0, 0, 1};
      vecs[2].c = '{1, 2, 3, 4};       vecs[2].gap = 0; vecs[2].stall = 1;
      vecs[3].a = '{1, 2, 3, 4};       vecs[3].b = '{5, 6, 7, 8};
      vecs[3].c = '{19, 22, 43, 50};   vecs[3].gap = 1; vecs[3].stall = 0;
      vecs[4].a = '{255, 1, 0, 3};     vecs[4].b = '{2, 0, 1, 4};
      vecs[4].c = '{255, 4, 3, 12};    vecs[4].gap = 1; vecs[4].stall = 1;

      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      stray_done = 1'b0;
      stub_en    = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start", start, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_error", error, 0);
      chk("rst_mat_A", mat_A, 0);
      chk("rst_mat_B", mat_B, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      for (int j = 0; j < 5; j++) run_job(vecs[j]);

      // Reset in the middle of WAIT, then a stray done that must be ignored.
      stub_en = 1'b0;
      load_job(vecs[3]);
      repeat (4) @(negedge clk);
      chk("wait_busy", busy, 1);
      chk("wait_start_held", start, 1);
      rst = 1'b1;
      #1;
      chk("midrst_start", start, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_mat_A", mat_A, 0);
      chk("midrst_mat_B", mat_B, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stray_out_valid", out_valid, 0);
         chk("stray_in_ready", in_ready, 1);
         chk("stray_start", start, 0);
      end
      stub_en = 1'b1;
      run_job(vecs[4]);

`ifdef ACC_MULT_TIMEOUT_EN
      begin
         int hi = 1;
         stub_en = 1'b0;
         load_job(vecs[1]);
         while (start && hi < 200) begin
            @(negedge clk);
            if (start) hi++;
         end
         chk("wd_start_cycles", hi, TMO + 1);
         chk("wd_error", error, 1);
         chk("wd_in_ready", in_ready, 1);
         chk("wd_out_valid", out_valid, 0);
         stub_en = 1'b1;
         run_job(vecs[3]);
         chk("wd_error_sticky", error, 1);
      end
`else
      chk("error_tied", error, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "simulation time limit reached");
   end
endmodule
